hall_input_filter: RTL and testbench

//  Conditions the three raw Hall sensor inputs (a,b,c) before the Hall position counter.
//  - Synchronises the asynchronous pins into clk.
//  - Debounces the 3-bit code as a vector.
//  - Decodes each accepted transition into a one-cycle forward/reverse step pulse.
//  - Flags illegal codes (000/111) and skipped sectors.

---
 rtl/hall_pkg.sv | 56 +++++
 rtl/hall_debounce.sv | 71 +++++++
 rtl/hall_input_filter.sv | 118 +++++++++++
 tb/tb_hall_input_filter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hall_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hall_pkg
// Description : Shared Hall-sensor definitions: the six legal sector codes in
//               forward order plus successor / legality helper functions.
//               Used by the input filter, the position counter and the
//               commutation logic, so the sequence is defined only here.
// Revision    : 1.0 - initial release
// ============================================================================
package hall_pkg;

    // Legal codes {a,b,c}, listed in forward rotation order.
    localparam logic [2:0] c_HALL_S0 = 3'b001;
    localparam logic [2:0] c_HALL_S1 = 3'b011;
    localparam logic [2:0] c_HALL_S2 = 3'b010;
    localparam logic [2:0] c_HALL_S3 = 3'b110;
    localparam logic [2:0] c_HALL_S4 = 3'b100;
    localparam logic [2:0] c_HALL_S5 = 3'b101;

    // All-low and all-high can never appear on a healthy sensor set.
    function automatic logic hall_is_legal(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    // Next code in forward rotation; illegal codes map to 000.
    function automatic logic [2:0] hall_fwd(input logic [2:0] code);
        logic [2:0] nxt;
        case (code)
            c_HALL_S0: nxt = c_HALL_S1;
            c_HALL_S1: nxt = c_HALL_S2;
            c_HALL_S2: nxt = c_HALL_S3;
            c_HALL_S3: nxt = c_HALL_S4;
            c_HALL_S4: nxt = c_HALL_S5;
            c_HALL_S5: nxt = c_HALL_S0;
            default:   nxt = 3'b000;
        endcase
        return nxt;
    endfunction

    // Next code in reverse rotation; illegal codes map to 000.
    function automatic logic [2:0] hall_rev(input logic [2:0] code);
        logic [2:0] nxt;
        case (code)
            c_HALL_S0: nxt = c_HALL_S5;
            c_HALL_S1: nxt = c_HALL_S0;
            c_HALL_S2: nxt = c_HALL_S1;
            c_HALL_S3: nxt = c_HALL_S2;
            c_HALL_S4: nxt = c_HALL_S3;
            c_HALL_S5: nxt = c_HALL_S4;
            default:   nxt = 3'b000;
        endcase
        return nxt;
    endfunction

endpackage : hall_pkg
`default_nettype wire

// File: rtl/hall_debounce.sv
`default_nettype none
// ============================================================================
// Module      : hall_debounce
// Description : Two-flop synchroniser followed by a 3-bit vector debounce.
//               A code is accepted once the synchronised value has been seen
//               on DEBOUNCE_CYCLES+1 consecutive edges and differs from the
//               last accepted code.
// Ports       : clk    - system clock
//               reset  - synchronous, active-high reset
//               din    - asynchronous Hall pins {a,b,c}
//               dout   - current debounce candidate (the code being accepted
//                        whenever accept is high)
//               accept - high during the cycle whose closing edge accepts
//                        dout; the parent registers dout on that edge
// Revision    : 1.0 - initial release
// ============================================================================
module hall_debounce #(
    parameter int DEBOUNCE_CYCLES = 16   // must be >= 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] din,
    output logic [2:0] dout,
    output logic       accept
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]         r_s1;
    logic [2:0]         r_s2;
    logic [2:0]         r_cand;
    logic [c_CNT_W-1:0] r_cnt;
    // Local copy of the last accepted code. It mirrors the parent's hall
    // register so that a candidate equal to the current code never
    // re-triggers an accept while the counter sits saturated.
    logic [2:0]         r_held;
    logic               w_accept;

    assign w_accept = (r_s2 == r_cand) && (r_cnt == c_CNT_LAST) && (r_cand != r_held);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= 3'b000;
            r_s2   <= 3'b000;
            r_cand <= 3'b000;
            r_cnt  <= '0;
            r_held <= 3'b000;
        end else begin
            // Plain register chain: nothing may sit between the two stages.
            r_s1 <= din;
            r_s2 <= r_s1;

            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= '0;
            end else if (r_cnt != c_CNT_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_accept) begin
                r_held <= r_cand;
            end
        end
    end

    assign dout   = r_cand;
    assign accept = w_accept;

endmodule : hall_debounce
`default_nettype wire

// File: rtl/hall_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : hall_input_filter
// Description : Conditions the raw Hall pins for the position counter:
//               synchronise, debounce as a vector, decode each accepted
//               transition into a forward/reverse step pulse and flag
//               illegal codes and skipped sectors.
// Ports       : clk         - system clock
//               reset       - synchronous, active-high reset
//               hall_raw    - asynchronous Hall pins {a,b,c}
//               err_clear   - one-cycle pulse clearing the sticky flags
//               hall        - filtered Hall code {a,b,c}
//               hall_valid  - hall is a legal code
//               step_fwd    - one-cycle pulse per accepted forward step
//               step_rev    - one-cycle pulse per accepted reverse step
//               dir         - last step direction (1 = forward)
//               illegal_err - sticky: an illegal code was accepted
//               skip_err    - sticky: a non-adjacent legal step was accepted
// Revision    : 1.0 - initial release
// ============================================================================
module hall_input_filter
    import hall_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] hall_raw,
    input  logic       err_clear,
    output logic [2:0] hall,
    output logic       hall_valid,
    output logic       step_fwd,
    output logic       step_rev,
    output logic       dir,
    output logic       illegal_err,
    output logic       skip_err
);

    logic [2:0] w_cand;
    logic       w_accept;
    logic       w_old_legal;
    logic       w_new_legal;
    logic       w_is_fwd;
    logic       w_is_rev;
    logic       w_set_illegal;
    logic       w_set_skip;

    logic [2:0] r_hall;
    logic       r_hall_valid;
    logic       r_step_fwd;
    logic       r_step_rev;
    logic       r_dir;
    logic       r_illegal_err;
    logic       r_skip_err;

    hall_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .din    (hall_raw),
        .dout   (w_cand),
        .accept (w_accept)
    );

    // Classification of the transition old = r_hall -> new = w_cand.
    // The successor comparisons are only meaningful for a legal old code
    // (hall_fwd/hall_rev return 000 otherwise), hence the w_old_legal gates.
    assign w_old_legal   = hall_is_legal(r_hall);
    assign w_new_legal   = hall_is_legal(w_cand);
    assign w_is_fwd      = w_old_legal && (w_cand == hall_fwd(r_hall));
    assign w_is_rev      = w_old_legal && (w_cand == hall_rev(r_hall));
    assign w_set_illegal = w_accept && !w_new_legal;
    assign w_set_skip    = w_accept && w_old_legal && w_new_legal && !w_is_fwd && !w_is_rev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hall        <= 3'b000;
            r_hall_valid  <= 1'b0;
            r_step_fwd    <= 1'b0;
            r_step_rev    <= 1'b0;
            r_dir         <= 1'b0;
            r_illegal_err <= 1'b0;
            r_skip_err    <= 1'b0;
        end else begin
            r_step_fwd <= 1'b0;
            r_step_rev <= 1'b0;

            if (w_accept) begin
                r_hall       <= w_cand;
                r_hall_valid <= w_new_legal;
                // Re-acquisition from an illegal code (including the
                // post-reset 000) falls through with no step and no error.
                if (w_is_fwd) begin
                    r_step_fwd <= 1'b1;
                    r_dir      <= 1'b1;
                end else if (w_is_rev) begin
                    r_step_rev <= 1'b1;
                    r_dir      <= 1'b0;
                end
            end

            // A set event in the same cycle as err_clear keeps the flag high.
            r_illegal_err <= w_set_illegal || (r_illegal_err && !err_clear);
            r_skip_err    <= w_set_skip    || (r_skip_err    && !err_clear);
        end
    end

    assign hall        = r_hall;
    assign hall_valid  = r_hall_valid;
    assign step_fwd    = r_step_fwd;
    assign step_rev    = r_step_rev;
    assign dir         = r_dir;
    assign illegal_err = r_illegal_err;
    assign skip_err    = r_skip_err;

endmodule : hall_input_filter
`default_nettype wire

// File: tb/tb_hall_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hall_input_filter
// Description : Self-checking bench for hall_input_filter. Directed scenarios
//               followed by randomized stimulus, all compared every cycle
//               against a window-based behavioural model: a code is taken
//               when the last DEBOUNCE_CYCLES+1 synchronised samples agree
//               and differ from the current code; steps are derived from
//               the code's position in the forward rotation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hall_input_filter;

    localparam int c_D = 4;
    localparam logic [2:0] c_SEQ [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    logic       clk;
    logic       reset;
    logic [2:0] hall_raw;
    logic       err_clear;
    logic [2:0] hall;
    logic       hall_valid;
    logic       step_fwd;
    logic       step_rev;
    logic       dir;
    logic       illegal_err;
    logic       skip_err;

    hall_input_filter #(
        .DEBOUNCE_CYCLES (c_D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hall_raw    (hall_raw),
        .err_clear   (err_clear),
        .hall        (hall),
        .hall_valid  (hall_valid),
        .step_fwd    (step_fwd),
        .step_rev    (step_rev),
        .dir         (dir),
        .illegal_err (illegal_err),
        .skip_err    (skip_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_fwd = 0;
    int cnt_rev = 0;

    // Reference model state
    logic [2:0] q_raw [$];   // raw samples, oldest first (length c_D+3)
    logic [2:0] m_hall;
    logic       m_valid;
    logic       m_fwd;
    logic       m_rev;
    logic       m_dir;
    logic       m_ill;
    logic       m_skip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int hall_pos(input logic [2:0] c);
        for (int i = 0; i < 6; i++)
            if (c_SEQ[i] == c) return i;
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [2:0] raw, input logic clr);
        logic stable;
        logic set_ill;
        logic set_skip;
        int   po;
        int   pn;
        if (rst) begin
            q_raw.delete();
            for (int i = 0; i < c_D + 3; i++) q_raw.push_back(3'b000);
            m_hall = 3'b000; m_valid = 1'b0; m_fwd = 1'b0; m_rev = 1'b0;
            m_dir = 1'b0; m_ill = 1'b0; m_skip = 1'b0;
            return;
        end
        q_raw.push_back(raw);
        void'(q_raw.pop_front());
        // Samples q_raw[0..c_D] are the ones visible after two sync stages.
        m_fwd = 1'b0; m_rev = 1'b0; set_ill = 1'b0; set_skip = 1'b0;
        stable = 1'b1;
        for (int i = 1; i <= c_D; i++)
            if (q_raw[i] != q_raw[0]) stable = 1'b0;
        if (stable && (q_raw[0] != m_hall)) begin
            po = hall_pos(m_hall);
            pn = hall_pos(q_raw[0]);
            if (pn < 0) set_ill = 1'b1;
            else if (po >= 0) begin
                if (pn == (po + 1) % 6)      begin m_fwd = 1'b1; m_dir = 1'b1; end
                else if (pn == (po + 5) % 6) begin m_rev = 1'b1; m_dir = 1'b0; end
                else set_skip = 1'b1;
            end
            m_hall  = q_raw[0];
            m_valid = (pn >= 0);
        end
        if (clr) begin m_ill = 1'b0; m_skip = 1'b0; end
        if (set_ill)  m_ill  = 1'b1;
        if (set_skip) m_skip = 1'b1;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model,
    // then compare every output 1 time unit after the edge.
    task automatic tick(input logic [2:0] raw, input logic clr, input logic rst);
        hall_raw  = raw;
        err_clear = clr;
        reset     = rst;
        @(posedge clk);
        model_step(rst, raw, clr);
        #1;
        check("hall",        hall,        m_hall);
        check("hall_valid",  hall_valid,  m_valid);
        check("step_fwd",    step_fwd,    m_fwd);
        check("step_rev",    step_rev,    m_rev);
        check("dir",         dir,         m_dir);
        check("illegal_err", illegal_err, m_ill);
        check("skip_err",    skip_err,    m_skip);
        if (step_fwd) cnt_fwd++;
        if (step_rev) cnt_rev++;
    endtask

    task automatic hold(input logic [2:0] code, input int n);
        for (int i = 0; i < n; i++) tick(code, 1'b0, 1'b0);
    endtask

    initial begin
        int f0;
        int r0;
        int lat;
        logic [2:0] tgt;
        int p;
        int len;

        hall_raw  = 3'b000;
        err_clear = 1'b0;
        reset     = 1'b1;

        // Reset and first acquisition latency
        tick(3'b001, 1'b0, 1'b1);
        check("reset_hall", hall, 3'b000);
        for (int k = 1; k <= 7; k++) begin
            tick(3'b001, 1'b0, 1'b0);
            if (k == 6) check("acq_before", hall, 3'b000);
        end
        check("acq_hall",  hall,       3'b001);
        check("acq_valid", hall_valid, 1'b1);
        hold(3'b001, 10);

        // Forward loop then reverse loop
        f0 = cnt_fwd; r0 = cnt_rev;
        for (int i = 1; i <= 6; i++) hold(c_SEQ[i % 6], 20);
        check("fwd_loop_steps", cnt_fwd - f0, 6);
        check("fwd_loop_rev",   cnt_rev - r0, 0);
        check("fwd_loop_dir",   dir, 1'b1);
        f0 = cnt_fwd; r0 = cnt_rev;
        for (int i = 5; i >= 0; i--) hold(c_SEQ[i], 20);
        check("rev_loop_steps", cnt_rev - r0, 6);
        check("rev_loop_fwd",   cnt_fwd - f0, 0);
        check("rev_loop_dir",   dir, 1'b0);

        // Excursion boundary: D samples rejected, D+1 accepted
        hold(3'b011, 20);
        f0 = cnt_fwd;
        hold(3'b010, c_D);
        hold(3'b011, 20);
        check("exc_short_hall",  hall, 3'b011);
        check("exc_short_steps", cnt_fwd - f0, 0);
        f0 = cnt_fwd;
        hold(3'b010, c_D + 1);
        hold(3'b010, 20);
        check("exc_long_hall",  hall, 3'b010);
        check("exc_long_steps", cnt_fwd - f0, 1);

        // Skip detection and err_clear priority
        hold(3'b001, 20);
        hold(3'b010, 20);
        check("skip_set", skip_err, 1'b1);
        tick(3'b010, 1'b1, 1'b0);
        check("skip_cleared", skip_err, 1'b0);
        hold(3'b101, c_D + 2);
        tick(3'b101, 1'b1, 1'b0);    // accept edge of a new skip
        check("skip_set_wins", skip_err, 1'b1);

        // Illegal code then re-acquisition
        hold(3'b110, 20);
        tick(3'b110, 1'b1, 1'b0);
        hold(3'b111, 20);
        check("illegal_set",   illegal_err, 1'b1);
        check("illegal_valid", hall_valid,  1'b0);
        hold(3'b100, 20);
        check("reacq_hall", hall,     3'b100);
        check("reacq_skip", skip_err, 1'b0);

        // Reset while a new code is two samples into debounce
        tick(3'b100, 1'b1, 1'b0);
        hold(3'b100, 10);
        hold(3'b101, 4);
        tick(3'b101, 1'b0, 1'b1);
        check("mid_reset_hall", hall,        3'b000);
        check("mid_reset_err",  illegal_err, 1'b0);
        lat = 0;
        do begin
            tick(3'b101, 1'b0, 1'b0);
            lat++;
        end while (hall == 3'b000 && lat < 40);
        check("mid_reset_latency", lat, c_D + 3);

        // Randomized stimulus
        tgt = 3'b101;
        for (int blk = 0; blk < 300; blk++) begin
            if ($urandom_range(0, 99) < 70) begin
                p = hall_pos(tgt);
                if (p < 0) tgt = c_SEQ[$urandom_range(0, 5)];
                else       tgt = c_SEQ[(p + (($urandom_range(0, 1) == 1) ? 1 : 5)) % 6];
            end else begin
                tgt = 3'($urandom_range(0, 7));
            end
            len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, c_D + 3))
                                              : int'($urandom_range(c_D + 1, 25));
            for (int i = 0; i < len; i++)
                tick(tgt, ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hall_input_filter
`default_nettype wire
